// File: rtl/scope_trigger_capture_if.sv
// rtl/scope_trigger_capture_if.sv - sample stream, trigger control, readout and status bundle for scope_trigger_capture
interface scope_trigger_capture_if #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 8
);
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic [DATA_W-1:0] trig_level;
  logic              trig_slope;
  logic              arm;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              auto_fired;

  // Producer / display side: drives samples, trigger setup and read address
  modport master (
    output sample_in, sample_valid, trig_level, trig_slope, arm, rd_addr,
    input  rd_data, busy, done, auto_fired
  );

  // Capture block side
  modport slave (
    input  sample_in, sample_valid, trig_level, trig_slope, arm, rd_addr,
    output rd_data, busy, done, auto_fired
  );
endinterface

// File: rtl/scope_trigger_capture.sv
// rtl/scope_trigger_capture.sv - circular sample recorder with level/slope trigger and frozen readout window (optional SCOPE_AUTO_TRIG_EN)
module scope_trigger_capture #(
  parameter int DATA_W       = 14,
  parameter int ADDR_W       = 8,
  parameter int PRETRIG      = 32,
  parameter int AUTO_TIMEOUT = 1024
) (
  input logic                    clk_i,
  input logic                    rst_n_i,
  scope_trigger_capture_if.slave bus
);

  localparam int DEPTH    = 1 << ADDR_W;
  localparam int POST_LEN = DEPTH - PRETRIG;
  localparam int CNT_W    = ADDR_W + 1;

  if (PRETRIG < 1 || PRETRIG > DEPTH - 1 || AUTO_TIMEOUT < 1) begin : g_param_check
    $error("scope_trigger_capture: PRETRIG must be 1..DEPTH-1 and AUTO_TIMEOUT >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFILL,
    S_WAIT_TRIG,
    S_POST,
    S_DONE
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] start_ptr_q;
  logic [ADDR_W-1:0] start_ptr_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] prev_sample_q;
  logic              prev_valid_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [ADDR_W-1:0] rd_idx;

  logic              wr_en;
  logic              rise_hit;
  logic              fall_hit;
  logic              real_trig;
  logic              trig_fire;

`ifdef SCOPE_AUTO_TRIG_EN
  localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);
  logic [TO_W-1:0]   to_cnt_q;
  logic              auto_fired_q;
  logic              auto_hit;
`endif

  // Write strobe, trigger detection and the window start derived from the trigger address
  always_comb begin
    wr_en       = bus.sample_valid &&
                  (state_q == S_PREFILL || state_q == S_WAIT_TRIG || state_q == S_POST);
    rise_hit    = (prev_sample_q < bus.trig_level) && (bus.sample_in >= bus.trig_level);
    fall_hit    = (prev_sample_q > bus.trig_level) && (bus.sample_in <= bus.trig_level);
    real_trig   = (state_q == S_WAIT_TRIG) && bus.sample_valid && prev_valid_q &&
                  (bus.trig_slope ? fall_hit : rise_hit);
`ifdef SCOPE_AUTO_TRIG_EN
    auto_hit    = (state_q == S_WAIT_TRIG) && bus.sample_valid &&
                  (to_cnt_q == TO_W'(AUTO_TIMEOUT - 1));
    trig_fire   = real_trig || auto_hit;
`else
    trig_fire   = real_trig;
`endif
    start_ptr_d = wr_ptr_q - ADDR_W'(PRETRIG);
    rd_idx      = start_ptr_q + bus.rd_addr;
  end

  // Capture sequencer: state, counters, pointers, previous sample and registered status
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      start_ptr_q   <= '0;
      cnt_q         <= '0;
      prev_sample_q <= '0;
      prev_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef SCOPE_AUTO_TRIG_EN
      to_cnt_q      <= '0;
      auto_fired_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          // A sample arriving with arm is not recorded: wr_en is low in these states
          if (bus.arm) begin
            state_q      <= S_PREFILL;
            cnt_q        <= '0;
            prev_valid_q <= 1'b0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
`ifdef SCOPE_AUTO_TRIG_EN
            auto_fired_q <= 1'b0;
`endif
          end
        end
        S_PREFILL: begin
          if (bus.sample_valid) begin
            if (cnt_q == CNT_W'(PRETRIG - 1)) begin
              state_q  <= S_WAIT_TRIG;
              cnt_q    <= '0;
`ifdef SCOPE_AUTO_TRIG_EN
              to_cnt_q <= '0;
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_WAIT_TRIG: begin
          if (bus.sample_valid) begin
            if (trig_fire) begin
              start_ptr_q  <= start_ptr_d;
              cnt_q        <= CNT_W'(1);
`ifdef SCOPE_AUTO_TRIG_EN
              auto_fired_q <= !real_trig;
`endif
              // With PRETRIG = DEPTH-1 the trigger sample alone completes the window
              if (POST_LEN == 1) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_POST;
              end
            end
`ifdef SCOPE_AUTO_TRIG_EN
            else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
`endif
          end
        end
        S_POST: begin
          if (bus.sample_valid) begin
            if (cnt_q == CNT_W'(POST_LEN - 1)) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase

      if (wr_en) begin
        wr_ptr_q      <= wr_ptr_q + 1'b1;
        prev_sample_q <= bus.sample_in;
        prev_valid_q  <= 1'b1;
      end
    end
  end

  // Sample RAM write port; contents are not reset
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= bus.sample_in;
    end
  end

  // Registered window readout relative to the frozen start pointer
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[rd_idx];
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
`ifdef SCOPE_AUTO_TRIG_EN
  assign bus.auto_fired = auto_fired_q;
`else
  assign bus.auto_fired = 1'b0;
`endif

endmodule
